// File: rtl/dpram_be_pipe_if.sv
// Bus bundle for dpram_be_pipe: clear control, write port, read port and status.
// Handshake: a write or read is taken at a rising edge only while busy is low; read_valid pulses once per taken read.
interface dpram_be_pipe_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int BYTE_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                     clear;
  logic                     busy;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     write_enable;
  logic [LANES-1:0]         write_byte_enable;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     read_enable;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     read_valid;
  logic                     fsm_state;

  modport master (
    output clear, write_address, write_data, write_enable, write_byte_enable,
           read_address, read_enable,
    input  busy, read_data, read_valid, fsm_state
  );

  modport slave (
    input  clear, write_address, write_data, write_enable, write_byte_enable,
           read_address, read_enable,
    output busy, read_data, read_valid, fsm_state
  );
endinterface

// File: rtl/dpram_be_pipe.sv
// Simple dual-port RAM with byte enables, 1- or 2-cycle registered read,
// selectable read-during-write behaviour and a zeroing sweep after reset/clear.
module dpram_be_pipe #(
  parameter int DATA_WIDTH    = 16,
  parameter int BYTE_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int READ_LATENCY  = 1,
  parameter int RDW_MODE      = 0
) (
  input logic          clock,
  input logic          reset,
  dpram_be_pipe_if.slave bus
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] sweep_addr, sweep_addr_next;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     busy;
  logic                     wr_go;
  logic                     rd_go;
  logic [DATA_WIDTH-1:0]    wr_word;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic [DATA_WIDTH-1:0]    stage_data;
  logic                     stage_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      sweep_addr <= '0;
    end else begin
      state      <= state_next;
      sweep_addr <= sweep_addr_next;
    end
  end

  // The sweep stops on the last address so it never spills a zero write into IDLE.
  always_comb begin
    state_next      = state;
    sweep_addr_next = sweep_addr;
    case (state)
      S_CLEAR: begin
        if (bus.clear) begin
          sweep_addr_next = '0;
        end else if (sweep_addr == '1) begin
          state_next      = S_IDLE;
          sweep_addr_next = '0;
        end else begin
          sweep_addr_next = sweep_addr + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.clear) begin
          state_next      = S_CLEAR;
          sweep_addr_next = '0;
        end
      end
      default: begin
        state_next      = S_CLEAR;
        sweep_addr_next = '0;
      end
    endcase
  end

  assign busy          = (state == S_CLEAR);
  assign bus.busy      = busy;
  assign bus.fsm_state = state;

  assign wr_go = bus.write_enable && !busy && (|bus.write_byte_enable);
  assign rd_go = bus.read_enable && !busy;

  always_comb begin
    wr_word = mem[bus.write_address];
    for (int i = 0; i < LANES; i++) begin
      if (bus.write_byte_enable[i]) begin
        wr_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Write-first forwarding: the merged word is exactly what the array will hold after this edge.
  always_comb begin
    rd_word = mem[bus.read_address];
    if ((RDW_MODE == 1) && wr_go && (bus.write_address == bus.read_address)) begin
      rd_word = wr_word;
    end
  end

  always_ff @(posedge clock) begin
    if (busy) begin
      mem[sweep_addr] <= '0;
    end else if (wr_go) begin
      mem[bus.write_address] <= wr_word;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_data     <= '0;
      stage_valid    <= 1'b0;
      bus.read_data  <= '0;
      bus.read_valid <= 1'b0;
    end else if (READ_LATENCY == 1) begin
      stage_valid    <= 1'b0;
      bus.read_valid <= rd_go;
      if (rd_go) begin
        bus.read_data <= rd_word;
      end
    end else begin
      stage_valid    <= rd_go;
      if (rd_go) begin
        stage_data <= rd_word;
      end
      bus.read_valid <= stage_valid;
      if (stage_valid) begin
        bus.read_data <= stage_data;
      end
    end
  end
endmodule

// File: tb/tb_dpram_be_pipe.sv
// Bench for dpram_be_pipe: two instances (latency 1/old-data and latency 2/write-first)
// share one stimulus stream and are compared every cycle against an array/queue model.
`timescale 1ns/1ps
module tb_dpram_be_pipe;
  localparam int DW    = 16;
  localparam int BW    = 8;
  localparam int AW    = 4;
  localparam int LANES = DW / BW;
  localparam int DEPTH = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic             clear, we, re;
  logic [AW-1:0]    wa, ra;
  logic [DW-1:0]    wd;
  logic [LANES-1:0] be;

  dpram_be_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW)) bus_a ();
  dpram_be_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW)) bus_b ();

  assign bus_a.clear = clear;  assign bus_b.clear = clear;
  assign bus_a.write_address = wa;  assign bus_b.write_address = wa;
  assign bus_a.write_data = wd;  assign bus_b.write_data = wd;
  assign bus_a.write_enable = we;  assign bus_b.write_enable = we;
  assign bus_a.write_byte_enable = be;  assign bus_b.write_byte_enable = be;
  assign bus_a.read_address = ra;  assign bus_b.read_address = ra;
  assign bus_a.read_enable = re;  assign bus_b.read_enable = re;

  dpram_be_pipe #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW),
                  .READ_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave));
  dpram_be_pipe #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDRESS_WIDTH(AW),
                  .READ_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave));

  // behavioural model
  logic [DW-1:0] mem_m [DEPTH];
  int            busy_left;
  int            cyc;
  logic [DW-1:0] exp_q_a[$], exp_q_b[$];
  int            due_q_a[$], due_q_b[$];
  logic [DW-1:0] exp_data_a, exp_data_b;
  logic          exp_valid_a, exp_valid_b;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    exp_q_a.delete(); exp_q_b.delete(); due_q_a.delete(); due_q_b.delete();
    exp_data_a = '0; exp_data_b = '0;
    exp_valid_a = 1'b0; exp_valid_b = 1'b0;
  endtask

  task automatic model_edge();
    logic [DW-1:0] old_w, new_w;
    bit idle;
    idle = (busy_left == 0);
    exp_valid_a = 1'b0;
    exp_valid_b = 1'b0;
    if (idle && re) begin
      old_w = mem_m[ra];
      new_w = old_w;
      if (we && wa == ra)
        for (int l = 0; l < LANES; l++) if (be[l]) new_w[l*BW +: BW] = wd[l*BW +: BW];
      exp_q_a.push_back(old_w); due_q_a.push_back(cyc);
      exp_q_b.push_back(new_w); due_q_b.push_back(cyc + 1);
    end
    if (idle && we)
      for (int l = 0; l < LANES; l++) if (be[l]) mem_m[wa][l*BW +: BW] = wd[l*BW +: BW];
    if (due_q_a.size() > 0 && due_q_a[0] == cyc) begin
      exp_data_a = exp_q_a.pop_front(); void'(due_q_a.pop_front()); exp_valid_a = 1'b1;
    end
    if (due_q_b.size() > 0 && due_q_b[0] == cyc) begin
      exp_data_b = exp_q_b.pop_front(); void'(due_q_b.pop_front()); exp_valid_b = 1'b1;
    end
    if (clear) begin
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    cyc++;
  endtask

  // compare process
  always @(negedge clock) begin
    check("busy_a", bus_a.busy, (busy_left > 0));
    check("busy_b", bus_b.busy, (busy_left > 0));
    check("valid_a", bus_a.read_valid, exp_valid_a);
    check("valid_b", bus_b.read_valid, exp_valid_b);
    check("data_a", bus_a.read_data, exp_data_a);
    check("data_b", bus_b.read_data, exp_data_b);
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
    if (reset) model_reset();
    else model_edge();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LANES-1:0] b);
    we = 1'b1; wa = a; wd = d; be = b;
    step();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    re = 1'b1; ra = a;
    step();
    re = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while (bus_a.busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    check(name, cnt, 16);
  endtask

  task automatic rand_cycle(input int same_pct, input int clear_pct);
    we    = ($urandom_range(0, 99) < 50);
    wa    = AW'($urandom_range(0, DEPTH - 1));
    wd    = DW'($urandom);
    be    = LANES'($urandom_range(0, 3));
    re    = ($urandom_range(0, 99) < 60);
    ra    = ($urandom_range(0, 99) < same_pct) ? wa : AW'($urandom_range(0, DEPTH - 1));
    clear = ($urandom_range(0, 99) < clear_pct);
    step();
    clear = 1'b0;
  endtask

  initial begin
    clear = 0; we = 0; re = 0; wa = '0; ra = '0; wd = '0; be = '0;
    cyc = 0;
    model_reset();
    repeat (3) step();
    check("rst_busy", bus_a.busy, 1);
    check("rst_valid_b", bus_b.read_valid, 0);
    check("rst_data_a", bus_a.read_data, 0);

    // sweep after reset, then every word reads zero
    reset = 1'b0;
    wait_idle("t1_busy_cycles");
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i));
      if (i == 0) begin
        check("t1_valid0", bus_a.read_valid, 1);
        check("t1_data0", bus_a.read_data, 16'h0000);
      end
    end
    step(); step();

    // byte-lane merge
    do_write(4'd3, 16'hA5C3, 2'b11);
    do_write(4'd3, 16'hFF11, 2'b01);
    do_read(4'd3);
    check("t2_data_a", bus_a.read_data, 16'hA511);
    step();
    check("t2_data_b", bus_b.read_data, 16'hA511);

    // read during write on the same address
    do_write(4'd5, 16'hA5C3, 2'b11);
    we = 1; wa = 4'd5; wd = 16'h1234; be = 2'b11; re = 1; ra = 4'd5;
    step();
    we = 0; re = 0;
    check("t3_old_a", bus_a.read_data, 16'hA5C3);
    step();
    check("t3_new_b", bus_b.read_data, 16'h1234);
    do_write(4'd5, 16'hA5C3, 2'b11);
    we = 1; wa = 4'd5; wd = 16'h1234; be = 2'b10; re = 1; ra = 4'd5;
    step();
    we = 0; re = 0;
    check("t3_old_part_a", bus_a.read_data, 16'hA5C3);
    step();
    check("t3_merge_b", bus_b.read_data, 16'h12C3);

    // back-to-back reads, latency 2 stream
    for (int k = 0; k < 18; k++) begin
      re = (k < 16);
      ra = AW'(k);
      step();
      check("t4_valid_b", bus_b.read_valid, (k >= 1 && k <= 16));
    end
    re = 0;

    // fill, clear, traffic ignored while busy, then all zero
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'($urandom) | 16'h0101, 2'b11);
    clear = 1;
    step();
    clear = 0;
    for (int k = 0; k < 16; k++) begin
      rand_cycle(30, 0);
      check("t5_no_valid_a", bus_a.read_valid, 0);
    end
    we = 0; re = 0;
    check("t5_idle", bus_a.busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i));
      check("t5_zero_a", bus_a.read_data, 16'h0000);
    end
    step(); step();

    // reset with a read in flight
    do_write(4'd3, 16'hBEEF, 2'b11);
    do_read(4'd3);
    check("t6_pre_a", bus_a.read_data, 16'hBEEF);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_async_data_a", bus_a.read_data, 0);
    check("t6_async_valid_a", bus_a.read_valid, 0);
    step();
    check("t6_discard_b", bus_b.read_valid, 0);
    reset = 1'b0;
    wait_idle("t6_busy_after_inflight");

    // reset at sweep address 7
    do_write(4'd10, 16'hBEEF, 2'b11);
    re = 1; ra = 4'd10; clear = 1;
    step();
    re = 0; clear = 0;
    repeat (7) step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_sweep_data_b", bus_b.read_data, 0);
    check("t6_sweep_busy", bus_b.busy, 1);
    step();
    reset = 1'b0;
    wait_idle("t6_busy_after_sweep");
    do_read(4'd10);
    step();
    check("t6_addr10_b", bus_b.read_data, 16'h0000);

    // randomized traffic
    for (int k = 0; k < 400; k++) rand_cycle((k < 200) ? 50 : 10, 1);
    we = 0; re = 0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
